mem_write_master: RTL and testbench

//  Initiator side of the Memory write port (we/w_cnt/w_dat/w_adr with stall handshake).

---
 rtl/mem_write_master_if.sv | 32 +++
 rtl/mem_write_master.sv | 184 ++++++++++++++++++
 tb/tb_mem_write_master.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_write_master_if.sv
// Store-request and Memory write-port signals of mem_write_master, grouped as one bundle.
// master = the write master itself; slave = its environment (writeback stage + Memory).
interface mem_write_master_if #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 8
);
    logic                   req_i;
    logic [1:0]             req_cnt_i;
    logic [3*DAT_WIDTH-1:0] req_dat_i;
    logic [ADR_WIDTH-1:0]   req_adr_i;
    logic                   req_rdy_o;

    logic                   we_o;
    logic [1:0]             w_cnt_o;
    logic [3*DAT_WIDTH-1:0] w_dat_o;
    logic [ADR_WIDTH-1:0]   w_adr_o;
    logic                   mem_stl_i;

    logic                   busy_o;
    logic                   done_o;
    logic                   err_o;

    modport master (
        input  req_i, req_cnt_i, req_dat_i, req_adr_i, mem_stl_i,
        output req_rdy_o, we_o, w_cnt_o, w_dat_o, w_adr_o, busy_o, done_o, err_o
    );

    modport slave (
        output req_i, req_cnt_i, req_dat_i, req_adr_i, mem_stl_i,
        input  req_rdy_o, we_o, w_cnt_o, w_dat_o, w_adr_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/mem_write_master.sv
// Buffers 1..3-byte store requests in a small FIFO and issues them one at a time to the
// Memory write port, waiting out the Memory stall on multi-byte writes.
module mem_write_master #(
    parameter int ADR_WIDTH   = 16,
    parameter int DAT_WIDTH   = 8,
    parameter int FIFO_DEPTH  = 2,
    parameter int STL_TIMEOUT = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    mem_write_master_if.master  bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = (STL_TIMEOUT > 1) ? $clog2(STL_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    typedef struct packed {
        logic [1:0]             cnt;
        logic [3*DAT_WIDTH-1:0] dat;
        logic [ADR_WIDTH-1:0]   adr;
    } entry_t;

    // FIFO
    entry_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [OCC_W-1:0]   occ_nxt;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    entry_t             head;

    // FSM and registered outputs
    state_t                 state;
    state_t                 state_nxt;
    logic [TMR_W-1:0]       timer;
    logic [TMR_W-1:0]       timer_nxt;
    logic                   we_q;
    logic                   we_nxt;
    logic [1:0]             w_cnt_q;
    logic [1:0]             w_cnt_nxt;
    logic [3*DAT_WIDTH-1:0] w_dat_q;
    logic [3*DAT_WIDTH-1:0] w_dat_nxt;
    logic [ADR_WIDTH-1:0]   w_adr_q;
    logic [ADR_WIDTH-1:0]   w_adr_nxt;
    logic                   done_q;
    logic                   done_nxt;
    logic                   err_q;
    logic                   err_nxt;
    logic                   timeout_hit;
    logic                   busy_q;
    logic                   busy_nxt;
    logic                   rdy_q;
    logic                   rdy_nxt;

    assign accept     = bus.req_i && rdy_q;
    assign push       = accept && (bus.req_cnt_i != 2'd0);
    assign fifo_empty = (occ == '0);
    assign head       = fifo_mem[rd_ptr];

    assign occ_nxt = occ + OCC_W'(push) - OCC_W'(pop);

    // NOTE: request storage has no reset; only pointers and occupancy qualify its contents.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{cnt: bus.req_cnt_i, dat: bus.req_dat_i, adr: bus.req_adr_i};
        end
    end

    // NOTE: every variable gets its default first, so no path through the case leaves one unassigned.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        we_nxt      = 1'b0;
        w_cnt_nxt   = '0;
        w_dat_nxt   = '0;
        w_adr_nxt   = '0;
        done_nxt    = 1'b0;
        timeout_hit = 1'b0;
        pop         = 1'b0;

        case (state)
            S_IDLE: begin
                // A stall seen here belongs to someone else or outlived a reset; hold off.
                if (!fifo_empty && !bus.mem_stl_i) begin
                    state_nxt = S_ISSUE;
                    we_nxt    = 1'b1;
                    w_cnt_nxt = head.cnt;
                    w_dat_nxt = head.dat;
                    w_adr_nxt = head.adr;
                end
            end

            S_ISSUE: begin
                pop = 1'b1;
                if (w_cnt_q == 2'd1) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    // Memory raises its stall on this same edge for multi-byte writes.
                    state_nxt = S_WAIT;
                    timer_nxt = '0;
                end
            end

            S_WAIT: begin
                if (!bus.mem_stl_i) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (timer == TMR_W'(STL_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A zero byte count completes the handshake but is recorded as a protocol fault.
    assign err_nxt  = err_q || timeout_hit || (accept && (bus.req_cnt_i == 2'd0));
    assign busy_nxt = (occ_nxt != '0) || (state_nxt != S_IDLE);
    assign rdy_nxt  = (occ_nxt != OCC_W'(FIFO_DEPTH));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            timer   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            we_q    <= 1'b0;
            w_cnt_q <= '0;
            w_dat_q <= '0;
            w_adr_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            occ     <= occ_nxt;
            we_q    <= we_nxt;
            w_cnt_q <= w_cnt_nxt;
            w_dat_q <= w_dat_nxt;
            w_adr_q <= w_adr_nxt;
            done_q  <= done_nxt;
            err_q   <= err_nxt;
            busy_q  <= busy_nxt;
            rdy_q   <= rdy_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    assign bus.req_rdy_o = rdy_q;
    assign bus.we_o      = we_q;
    assign bus.w_cnt_o   = w_cnt_q;
    assign bus.w_dat_o   = w_dat_q;
    assign bus.w_adr_o   = w_adr_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;

endmodule

// File: tb/tb_mem_write_master.sv
// Randomised and directed bench for mem_write_master: a queue-based reference model predicts
// issue order, done/err timing and final memory contents; a small Memory model drives the stall.
module tb_mem_write_master;

    localparam int ADR_WIDTH   = 16;
    localparam int DAT_WIDTH   = 8;
    localparam int FIFO_DEPTH  = 2;
    localparam int STL_TIMEOUT = 8;
    localparam int NEVER       = 32'h7fff_ffff;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    mem_write_master_if #(.ADR_WIDTH(ADR_WIDTH), .DAT_WIDTH(DAT_WIDTH)) bus ();

    mem_write_master #(
        .ADR_WIDTH  (ADR_WIDTH),
        .DAT_WIDTH  (DAT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .STL_TIMEOUT(STL_TIMEOUT)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  cnt;
        logic [15:0] adr;
        logic [23:0] dat;
    } wr_t;

    int errors = 0;
    int checks = 0;

    wr_t        exp_q[$];
    int         done_q[$];
    int         cyc        = 0;
    int         err_at     = NEVER;
    logic       err_exp    = 1'b0;
    logic       rdy_exp    = 1'b1;
    int         stall_left = 0;
    logic       stl_model  = 1'b0;
    logic       force_stl  = 1'b0;
    int         long_len   = 0;
    int         done_count = 0;
    logic [7:0] mem     [int];
    logic [7:0] ref_mem [int];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_at(input int k);
        return mem.exists(k) ? mem[k] : 8'hxx;
    endfunction

    task automatic set_force(input logic v);
        force_stl     = v;
        bus.mem_stl_i = stl_model | force_stl;
    endtask

    // One cycle: sample at the falling edge, compare with the model, advance the Memory model.
    task automatic tick();
        int new_stall;
        logic exp_done;
        new_stall = 0;
        @(negedge clk_i);
        cyc++;
        rdy_exp = (exp_q.size() < FIFO_DEPTH);
        if (!rst_i) begin
            check("rdy", bus.req_rdy_o, rdy_exp);
            if (bus.we_o) begin
                check("we_vs_stall", bus.mem_stl_i, 1'b0);
                if (exp_q.size() == 0) begin
                    check("we_unexpected", bus.we_o, 1'b0);
                end else begin
                    wr_t e;
                    int  l;
                    e = exp_q.pop_front();
                    check("w_cnt", bus.w_cnt_o, e.cnt);
                    check("w_adr", bus.w_adr_o, e.adr);
                    check("w_dat", bus.w_dat_o, e.dat);
                    for (int i = 0; i < int'(bus.w_cnt_o); i++) begin
                        mem[(int'(bus.w_adr_o) + i) & 16'hffff] = bus.w_dat_o[8*i +: 8];
                    end
                    if (e.cnt == 2'd1) begin
                        done_q.push_back(cyc + 1);
                    end else begin
                        l = (long_len > 0) ? long_len : int'(e.cnt);
                        new_stall = l;
                        if (l < STL_TIMEOUT) done_q.push_back(cyc + 2 + l);
                        else if (cyc + 1 + STL_TIMEOUT < err_at) err_at = cyc + 1 + STL_TIMEOUT;
                    end
                end
            end else begin
                check("w_bus_idle", {bus.w_cnt_o, bus.w_adr_o, bus.w_dat_o}, 64'd0);
            end
            exp_done = (done_q.size() > 0) && (done_q[0] == cyc);
            if (exp_done) void'(done_q.pop_front());
            check("done", bus.done_o, exp_done);
            if (bus.done_o) done_count++;
            if (cyc >= err_at) err_exp = 1'b1;
            check("err", bus.err_o, err_exp);
        end
        if (stall_left > 0) begin
            stl_model = 1'b1;
            stall_left--;
        end else begin
            stl_model = 1'b0;
        end
        if (new_stall > 0) stall_left = new_stall;
        bus.mem_stl_i = stl_model | force_stl;
    endtask

    task automatic send(input logic [1:0] c, input logic [15:0] a, input logic [23:0] d);
        bit accepted;
        accepted      = 1'b0;
        bus.req_i     = 1'b1;
        bus.req_cnt_i = c;
        bus.req_adr_i = a;
        bus.req_dat_i = d;
        for (int t = 0; t < 64 && !accepted; t++) begin
            if (rdy_exp) begin
                accepted = 1'b1;
                if (c == 2'd0) begin
                    if (cyc + 1 < err_at) err_at = cyc + 1;
                end else begin
                    exp_q.push_back('{cnt: c, adr: a, dat: d});
                    for (int i = 0; i < int'(c); i++) begin
                        ref_mem[(int'(a) + i) & 16'hffff] = d[8*i +: 8];
                    end
                end
            end
            tick();
        end
        bus.req_i = 1'b0;
        if (!accepted) check("send_timeout", accepted, 1'b1);
    endtask

    task automatic drain();
        bit drained;
        drained = 1'b0;
        bus.req_i = 1'b0;
        for (int t = 0; t < 300 && !drained; t++) begin
            if (exp_q.size() == 0 && done_q.size() == 0 && stall_left == 0 && !stl_model &&
                (err_at == NEVER || cyc >= err_at)) drained = 1'b1;
            else tick();
        end
        check("drain", drained, 1'b1);
        repeat (2) tick();
        check("idle_busy", bus.busy_o, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic apply_reset();
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_outs", {bus.we_o, bus.done_o, bus.err_o, bus.busy_o,
                           bus.w_cnt_o, bus.w_adr_o, bus.w_dat_o}, 64'd0);
        exp_q.delete();
        done_q.delete();
        err_at     = NEVER;
        err_exp    = 1'b0;
        stall_left = 0;
        stl_model  = 1'b0;
        bus.mem_stl_i = force_stl;
        repeat (2) tick();
        rst_i = 1'b0;
        rdy_exp = 1'b1;
        #1;
        check("rst_rdy", bus.req_rdy_o, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        int d0;
        bus.req_i     = 1'b0;
        bus.req_cnt_i = '0;
        bus.req_adr_i = '0;
        bus.req_dat_i = '0;
        bus.mem_stl_i = 1'b0;
        tick();
        apply_reset();
        tick();

        // 1) single byte: latency, write contents, done one cycle after we_o
        send(2'd1, 16'h0003, 24'h0000AA);
        check("t1_we_early", bus.we_o, 1'b0);
        tick();
        check("t1_we", bus.we_o, 1'b1);
        check("t1_adr", bus.w_adr_o, 16'h0003);
        tick();
        check("t1_done", bus.done_o, 1'b1);
        check("t1_mem", mem_at(3), 8'hAA);
        drain();

        // 2) three bytes with a three-cycle Memory stall
        d0 = done_count;
        send(2'd3, 16'h8000, 24'h332211);
        drain();
        check("t2_done_once", done_count - d0, 1);
        check("t2_mem", {mem_at(32'h8002), mem_at(32'h8001), mem_at(32'h8000)}, 24'h332211);

        // 3) FIFO fills under a held stall; third request waits, then all three issue in order
        set_force(1'b1);
        send(2'd1, 16'h0010, 24'h000011);
        send(2'd1, 16'h0011, 24'h000022);
        bus.req_i     = 1'b1;
        bus.req_cnt_i = 2'd1;
        bus.req_adr_i = 16'h0012;
        bus.req_dat_i = 24'h000033;
        repeat (3) tick();
        check("t3_rdy_full", bus.req_rdy_o, 1'b0);
        check("t3_no_we", bus.we_o, 1'b0);
        check("t3_busy", bus.busy_o, 1'b1);
        set_force(1'b0);
        send(2'd1, 16'h0012, 24'h000033);
        drain();
        check("t3_mem", {mem_at(32'h12), mem_at(32'h11), mem_at(32'h10)}, 24'h332211);

        // 5a) stall of STL_TIMEOUT-1 WAIT cycles still completes normally
        d0 = done_count;
        long_len = STL_TIMEOUT - 1;
        send(2'd2, 16'h1234, 24'h00BEEF);
        drain();
        check("t5a_done", done_count - d0, 1);
        check("t5a_err", bus.err_o, 1'b0);

        // 5) stall held for 20 cycles: fault after STL_TIMEOUT WAIT cycles, no done
        d0 = done_count;
        long_len = 20;
        send(2'd2, 16'h2000, 24'h00CAFE);
        drain();
        long_len = 0;
        check("t5_err", bus.err_o, 1'b1);
        check("t5_no_done", done_count - d0, 0);

        // 4) zero byte count: accepted, nothing written, sticky error until reset
        apply_reset();
        tick();
        check("t4_err_clear", bus.err_o, 1'b0);
        send(2'd0, 16'h0050, 24'h123456);
        repeat (6) tick();
        check("t4_err", bus.err_o, 1'b1);
        check("t4_busy", bus.busy_o, 1'b0);

        // random traffic with varying gaps
        for (int k = 0; k < 40; k++) begin
            send(2'($urandom_range(1, 3)), 16'($urandom), 24'($urandom));
            bus.req_i = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        check("rand_err_sticky", bus.err_o, 1'b1);

        foreach (ref_mem[k]) check("mem", mem_at(k), ref_mem[k]);
        check("mem_size", mem.size(), ref_mem.size());

        // 6) reset in WAIT of a 3-byte write, stall kept high; no issue until it drops
        long_len = 20;
        send(2'd3, 16'h4000, 24'h0A0B0C);
        for (int t = 0; t < 10 && !bus.we_o; t++) tick();
        check("t6_we_seen", bus.we_o, 1'b1);
        long_len = 0;
        repeat (3) tick();
        set_force(1'b1);
        apply_reset();
        tick();
        send(2'd1, 16'h0777, 24'h000055);
        repeat (5) tick();
        check("t6_hold", bus.we_o, 1'b0);
        check("t6_busy", bus.busy_o, 1'b1);
        n0 = done_count;
        set_force(1'b0);
        drain();
        check("t6_done", done_count - n0, 1);
        check("t6_mem", mem_at(32'h0777), 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
